spi_slave_regif: RTL and testbench

SPI Mode 0 responder (CPOL=0, CPHA=0, MSB first, active-low CS) that bridges an external SPI initiator to a parallel register bus. It uses the same frame format as the sensor link: the command byte has bit7 = 1 for read and 0 for write, and bits[6:0] give the start address. Each following data byte auto-increments the address. The block serves as an on-FPGA register-access port and as a synthesizable ICM-42688-P stand-in for closed-loop tests against spi_master.

---
 rtl/spi_slave_regif.sv | 160 ++++++++++++++++
 tb/tb_spi_slave_regif.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regif.sv
// SPI mode-0 responder bridging an external initiator to a parallel register bus.
// Command byte: bit7 = read, bits[6:0] = start address; data bytes auto-increment.
module spi_slave_regif #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sck_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_n_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic [6:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       cs_active_o,
  output logic       frame_done_o,
  output logic       frame_abort_o
);

  localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t        state;
  logic [SS-1:0] sck_sync, mosi_sync, cs_sync;
  logic          sck_prev, cs_prev;
  logic          sck_s, mosi_s, cs_s;
  logic          sck_rise, sck_fall, cs_fall, cs_rise;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_shift, tx_shift, rd_buf;
  logic [7:0]    rx_next;
  logic [6:0]    addr;
  logic          rw, byte_seen, cap_pend;

  assign sck_s    = sck_sync[SS-1];
  assign mosi_s   = mosi_sync[SS-1];
  assign cs_s     = cs_sync[SS-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_fall  = ~cs_s & cs_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign rx_next  = {rx_shift[6:0], mosi_s};

  // CS chain clears to "asserted" so a reset mid-frame cannot fake a falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SS-2:0], spi_sck_i};
      mosi_sync <= {mosi_sync[SS-2:0], spi_mosi_i};
      cs_sync   <= {cs_sync[SS-2:0], spi_cs_n_i};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      rx_shift      <= 8'h00;
      tx_shift      <= 8'h00;
      rd_buf        <= 8'h00;
      addr          <= 7'h00;
      rw            <= 1'b0;
      byte_seen     <= 1'b0;
      cap_pend      <= 1'b0;
      spi_miso_o    <= 1'b0;
      spi_miso_oe_o <= 1'b0;
      reg_addr_o    <= 7'h00;
      reg_wdata_o   <= 8'h00;
      reg_we_o      <= 1'b0;
      reg_re_o      <= 1'b0;
      cs_active_o   <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_abort_o <= 1'b0;
    end else begin
      reg_we_o      <= 1'b0;
      reg_re_o      <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_abort_o <= 1'b0;
      // Read data arrives the cycle after the strobe; capture it and advance.
      cap_pend      <= reg_re_o;
      if (cap_pend) begin
        rd_buf <= reg_rdata_i;
        addr   <= addr + 7'd1;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state         <= CMD;
            bit_cnt       <= 3'd0;
            rx_shift      <= 8'h00;
            tx_shift      <= 8'h00;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b1;
            cs_active_o   <= 1'b1;
            byte_seen     <= 1'b0;
            rw            <= 1'b0;
          end
        end
        default: begin
          if (cs_rise) begin
            state         <= IDLE;
            tx_shift      <= 8'h00;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            cs_active_o   <= 1'b0;
            if (bit_cnt == 3'd0 && byte_seen) frame_done_o  <= 1'b1;
            else                              frame_abort_o <= 1'b1;
          end else if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_seen <= 1'b1;
              if (state == CMD) begin
                state <= DATA;
                rw    <= rx_next[7];
                addr  <= rx_next[6:0];
                if (rx_next[7]) begin
                  reg_re_o   <= 1'b1;
                  reg_addr_o <= rx_next[6:0];
                end
              end else if (rw) begin
                // Prefetch for the next byte, including after the final one.
                reg_re_o   <= 1'b1;
                reg_addr_o <= addr;
              end else begin
                reg_we_o    <= 1'b1;
                reg_addr_o  <= addr;
                reg_wdata_o <= rx_next;
                addr        <= addr + 7'd1;
              end
            end
          end else if (sck_fall) begin
            if (bit_cnt != 3'd0) begin
              tx_shift   <= {tx_shift[6:0], 1'b0};
              spi_miso_o <= tx_shift[6];
            end else if (state == DATA && rw) begin
              tx_shift   <= rd_buf;
              spi_miso_o <= rd_buf[7];
            end else begin
              tx_shift   <= 8'h00;
              spi_miso_o <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Self-checking bench for spi_slave_regif: SPI initiator model, register model and strobe scoreboard.
module tb_spi_slave_regif;

  localparam int HALF = 8;

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [7:0] data;
  } strb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_miso, spi_miso_oe;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       cs_active, frame_done, frame_abort;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  logic [7:0] mem [128];
  strb_t      exp_strb [$];
  logic [7:0] exp_miso [$];
  logic [7:0] tx_q [$];
  logic [7:0] rx_got [$];
  strb_t      mon_e;

  spi_slave_regif #(.SYNC_STAGES(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .spi_sck_i     (spi_sck),
    .spi_mosi_i    (spi_mosi),
    .spi_cs_n_i    (spi_cs_n),
    .spi_miso_o    (spi_miso),
    .spi_miso_oe_o (spi_miso_oe),
    .reg_addr_o    (reg_addr),
    .reg_wdata_o   (reg_wdata),
    .reg_we_o      (reg_we),
    .reg_re_o      (reg_re),
    .reg_rdata_i   (reg_rdata),
    .cs_active_o   (cs_active),
    .frame_done_o  (frame_done),
    .frame_abort_o (frame_abort)
  );

  always #5 clk = ~clk;

  // Register model: read data valid the cycle after the strobe.
  always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

  // Strobe scoreboard and frame-pulse counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we && reg_re) begin
        tests++; fails++;
        $display("FAIL strb_both we=1 re=1 required exclusive");
      end
      if (reg_we || reg_re) begin
        tests++;
        if (exp_strb.size() == 0) begin
          fails++;
          $display("FAIL strb_unexpected got we=%0b addr=%h data=%h required none", reg_we, reg_addr, reg_wdata);
        end else begin
          mon_e = exp_strb.pop_front();
          if (reg_we !== mon_e.we || reg_addr !== mon_e.addr || (mon_e.we && reg_wdata !== mon_e.data)) begin
            fails++;
            $display("FAIL strb got we=%0b addr=%h data=%h required we=%0b addr=%h data=%h",
                     reg_we, reg_addr, reg_wdata, mon_e.we, mon_e.addr, mon_e.data);
          end
        end
      end
      if (frame_done) done_cnt++;
      if (frame_abort) abort_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  // Sends nfull whole bytes from tx_q, then optionally a partial byte, then deasserts CS.
  task automatic run_frame(input int nfull, input int partial_bits);
    logic [7:0] rx;
    rx_got.delete();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    tests++;
    if (cs_active !== 1'b1 || spi_miso_oe !== 1'b1) begin
      fails++;
      $display("FAIL cs_active_start got active=%0b oe=%0b required 1 1", cs_active, spi_miso_oe);
    end
    for (int b = 0; b < nfull; b++) begin
      spi_byte(tx_q[b], 8, rx);
      rx_got.push_back(rx);
    end
    if (partial_bits > 0) spi_byte(tx_q[nfull], partial_bits, rx);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4*HALF) @(negedge clk);
    tests++;
    if (cs_active !== 1'b0 || spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
      fails++;
      $display("FAIL cs_idle got active=%0b oe=%0b miso=%0b required 0 0 0", cs_active, spi_miso_oe, spi_miso);
    end
  endtask

  task automatic check_frame(input string name, input int done_exp, input int abort_exp,
                             input int done0, input int abort0);
    logic [7:0] e;
    for (int i = 0; i < rx_got.size(); i++) begin
      tests++;
      if (exp_miso.size() == 0) begin
        fails++;
        $display("FAIL %s_miso[%0d] got %h required none", name, i, rx_got[i]);
      end else begin
        e = exp_miso.pop_front();
        if (rx_got[i] !== e) begin
          fails++;
          $display("FAIL %s_miso[%0d] got %h required %h", name, i, rx_got[i], e);
        end
      end
    end
    tests++;
    if (exp_strb.size() != 0 || exp_miso.size() != 0) begin
      fails++;
      $display("FAIL %s_leftover got strb=%0d miso=%0d required 0 0", name, exp_strb.size(), exp_miso.size());
      exp_strb.delete(); exp_miso.delete();
    end
    tests++;
    if (done_cnt - done0 != done_exp || abort_cnt - abort0 != abort_exp) begin
      fails++;
      $display("FAIL %s_pulses got done=%0d abort=%0d required %0d %0d", name,
               done_cnt - done0, abort_cnt - abort0, done_exp, abort_exp);
    end
  endtask

  task automatic read_frame(input string name, input logic [6:0] a, input int n);
    int d0 = done_cnt, a0 = abort_cnt;
    logic [6:0] p = a;
    tx_q.delete();
    tx_q.push_back({1'b1, a});
    exp_miso.push_back(8'h00);
    for (int i = 0; i <= n; i++) begin
      exp_strb.push_back({1'b0, p, 8'h00});
      if (i < n) begin
        exp_miso.push_back(mem[p]);
        tx_q.push_back(8'($urandom_range(0, 255)));
      end
      p = p + 7'd1;
    end
    run_frame(n + 1, 0);
    check_frame(name, 1, 0, d0, a0);
  endtask

  task automatic write_frame(input string name, input logic [6:0] a, input logic [7:0] d [$]);
    int d0 = done_cnt, a0 = abort_cnt;
    logic [6:0] p = a;
    tx_q.delete();
    tx_q.push_back({1'b0, a});
    exp_miso.push_back(8'h00);
    foreach (d[i]) begin
      tx_q.push_back(d[i]);
      exp_strb.push_back({1'b1, p, d[i]});
      exp_miso.push_back(8'h00);
      p = p + 7'd1;
    end
    run_frame(d.size() + 1, 0);
    check_frame(name, 1, 0, d0, a0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, cs_active, frame_done, frame_abort} !== 22'h0) begin
      fails++;
      $display("FAIL reset_outputs got %h required 0",
               {spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, cs_active, frame_done, frame_abort});
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_who_am_i;
    read_frame("who_am_i", 7'h75, 1);
  endtask

  task automatic test_write_burst;
    logic [7:0] d [$];
    d = '{8'hA5, 8'h5A};
    write_frame("write_burst", 7'h10, d);
  endtask

  task automatic test_burst_read;
    read_frame("burst_read", 7'h1D, 14);
  endtask

  task automatic test_wrap;
    read_frame("wrap", 7'h7F, 2);
  endtask

  task automatic test_abort;
    int d0 = done_cnt, a0 = abort_cnt;
    logic [7:0] d [$];
    tx_q.delete();
    tx_q.push_back(8'h20);
    tx_q.push_back(8'hFF);
    exp_miso.push_back(8'h00);
    run_frame(1, 4);
    check_frame("abort", 0, 1, d0, a0);
    d = '{8'h3C};
    write_frame("after_abort", 7'h20, d);
  endtask

  task automatic test_reset_mid_frame;
    int d0 = done_cnt, a0 = abort_cnt;
    logic [7:0] rx;
    exp_strb.push_back({1'b0, 7'h10, 8'h00});
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_byte(8'h90, 8, rx);
    spi_byte(8'h00, 3, rx);
    rst = 1'b1;
    #1;
    tests++;
    if ({spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, cs_active, frame_done, frame_abort} !== 22'h0) begin
      fails++;
      $display("FAIL reset_mid_outputs got %h required 0",
               {spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, cs_active, frame_done, frame_abort});
    end
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4*HALF) @(negedge clk);
    rx_got.delete();
    check_frame("reset_mid", 0, 0, d0, a0);
    read_frame("after_reset", 7'h10, 1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hFF;
    mem[7'h75] = 8'h47;
    mem[7'h7F] = 8'h11;
    mem[7'h00] = 8'h22;
    test_reset();
    test_who_am_i();
    test_write_burst();
    test_burst_read();
    test_wrap();
    test_abort();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
